mem_port_arbiter: RTL and testbench

//  Shares the single data port of Mem (DataAddr/DataSize/DataIn/DataOut/WE) between two requesters:
//  r0 = PipelinedCPU MEM stage, r1 = debug/DMA loader. Grants one access per cycle, round-robin or fixed

---
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single Mem data port: round-robin or fixed priority,
// bounded lock ownership, and registered load return one cycle after acceptance.
module mem_port_arbiter #(
    parameter bit          FAIR     = 1'b1,
    parameter int unsigned MAX_LOCK = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        r0_req,
    input  logic        r0_we,
    input  logic [31:0] r0_addr,
    input  logic [1:0]  r0_size,
    input  logic [31:0] r0_wdata,
    input  logic        r0_lock,
    output logic        r0_gnt,
    output logic        r0_rvalid,
    output logic [31:0] r0_rdata,
    input  logic        r1_req,
    input  logic        r1_we,
    input  logic [31:0] r1_addr,
    input  logic [1:0]  r1_size,
    input  logic [31:0] r1_wdata,
    input  logic        r1_lock,
    output logic        r1_gnt,
    output logic        r1_rvalid,
    output logic [31:0] r1_rdata,
    output logic [31:0] mem_addr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    // Handshake: a request is accepted in the cycle where rN_req and rN_gnt are both high;
    // the requester holds its fields stable until then, and loads return rvalid/rdata next cycle.

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } own_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_LOCK);

    own_t        own_q, own_d;
    logic        rr_last_q, rr_last_d;
    logic [3:0]  lock_cnt_q, lock_cnt_d;
    logic        r0_rvalid_q, r0_rvalid_d;
    logic        r1_rvalid_q, r1_rvalid_d;
    logic [31:0] r0_rdata_q, r0_rdata_d;
    logic [31:0] r1_rdata_q, r1_rdata_d;

    logic        gnt0, gnt1;
    logic        lock_full;
    logic        win_lock;
    own_t        win_own;

    assign lock_full = (lock_cnt_q >= MAX_CNT);

    // Grants are gated by reset so nothing reaches Mem while RST is low.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!RST) begin
            gnt0 = 1'b0;
        end else if (own_q == OWN0 && r0_req) begin
            if (lock_full && r1_req) gnt1 = 1'b1;
            else                     gnt0 = 1'b1;
        end else if (own_q == OWN1 && r1_req) begin
            if (lock_full && r0_req) gnt0 = 1'b1;
            else                     gnt1 = 1'b1;
        end else if (r0_req && r1_req) begin
            if (FAIR && !rr_last_q) gnt1 = 1'b1;
            else                    gnt0 = 1'b1;
        end else if (r0_req) begin
            gnt0 = 1'b1;
        end else if (r1_req) begin
            gnt1 = 1'b1;
        end
    end

    assign r0_gnt    = gnt0;
    assign r1_gnt    = gnt1;
    assign mem_addr  = gnt1 ? r1_addr  : r0_addr;
    assign mem_size  = gnt1 ? r1_size  : r0_size;
    assign mem_wdata = gnt1 ? r1_wdata : r0_wdata;
    assign mem_we    = (gnt1 & r1_we) | (gnt0 & r0_we);

    always_comb begin
        win_lock    = gnt1 ? r1_lock : r0_lock;
        win_own     = gnt1 ? OWN1 : OWN0;
        own_d       = IDLE;
        lock_cnt_d  = 4'd0;
        rr_last_d   = rr_last_q;
        if (gnt0 || gnt1) begin
            rr_last_d = gnt1;
            if (win_lock) begin
                own_d = win_own;
                if (own_q == win_own)
                    lock_cnt_d = lock_full ? lock_cnt_q : lock_cnt_q + 4'd1;
                else
                    lock_cnt_d = 4'd1;
            end
        end
        r0_rvalid_d = gnt0 & ~r0_we;
        r1_rvalid_d = gnt1 & ~r1_we;
        r0_rdata_d  = r0_rvalid_d ? mem_rdata : r0_rdata_q;
        r1_rdata_d  = r1_rvalid_d ? mem_rdata : r1_rdata_q;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            own_q       <= IDLE;
            rr_last_q   <= 1'b1;
            lock_cnt_q  <= 4'd0;
            r0_rvalid_q <= 1'b0;
            r1_rvalid_q <= 1'b0;
            r0_rdata_q  <= 32'd0;
            r1_rdata_q  <= 32'd0;
        end else begin
            own_q       <= own_d;
            rr_last_q   <= rr_last_d;
            lock_cnt_q  <= lock_cnt_d;
            r0_rvalid_q <= r0_rvalid_d;
            r1_rvalid_q <= r1_rvalid_d;
            r0_rdata_q  <= r0_rdata_d;
            r1_rdata_q  <= r1_rdata_d;
        end
    end

    assign r0_rvalid = r0_rvalid_q;
    assign r1_rvalid = r1_rvalid_q;
    assign r0_rdata  = r0_rdata_q;
    assign r1_rdata  = r1_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a round-robin and a fixed-priority instance share stimulus,
// a per-cycle reference model checks both, and literal expectations pin the key scenarios.
module tb_mem_port_arbiter;

    localparam int MAXL = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic [1:0]  req, we, lock;
    logic [31:0] addr_i [2];
    logic [1:0]  size_i [2];
    logic [31:0] wdata_i [2];

    logic [1:0]  o_gnt [2];
    logic [1:0]  o_rv [2];
    logic [31:0] o_rd [2][2];
    logic [31:0] o_addr [2];
    logic [1:0]  o_size [2];
    logic [31:0] o_wd [2];
    logic        o_we [2];
    logic [31:0] m_rdata [2];

    logic [7:0]  mem [256];
    logic        mem_init = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    int          own_m [2];
    int          held_m [2];
    int          last_m [2];
    logic        erv [2][2];
    logic [31:0] erd [2][2];

    always #5 CLK = ~CLK;

    mem_port_arbiter #(.FAIR(1'b1), .MAX_LOCK(MAXL)) dut (
        .CLK(CLK), .RST(RST),
        .r0_req(req[0]), .r0_we(we[0]), .r0_addr(addr_i[0]), .r0_size(size_i[0]),
        .r0_wdata(wdata_i[0]), .r0_lock(lock[0]), .r0_gnt(o_gnt[0][0]),
        .r0_rvalid(o_rv[0][0]), .r0_rdata(o_rd[0][0]),
        .r1_req(req[1]), .r1_we(we[1]), .r1_addr(addr_i[1]), .r1_size(size_i[1]),
        .r1_wdata(wdata_i[1]), .r1_lock(lock[1]), .r1_gnt(o_gnt[0][1]),
        .r1_rvalid(o_rv[0][1]), .r1_rdata(o_rd[0][1]),
        .mem_addr(o_addr[0]), .mem_size(o_size[0]), .mem_wdata(o_wd[0]), .mem_we(o_we[0]),
        .mem_rdata(m_rdata[0])
    );

    mem_port_arbiter #(.FAIR(1'b0), .MAX_LOCK(MAXL)) dut_fp (
        .CLK(CLK), .RST(RST),
        .r0_req(req[0]), .r0_we(we[0]), .r0_addr(addr_i[0]), .r0_size(size_i[0]),
        .r0_wdata(wdata_i[0]), .r0_lock(lock[0]), .r0_gnt(o_gnt[1][0]),
        .r0_rvalid(o_rv[1][0]), .r0_rdata(o_rd[1][0]),
        .r1_req(req[1]), .r1_we(we[1]), .r1_addr(addr_i[1]), .r1_size(size_i[1]),
        .r1_wdata(wdata_i[1]), .r1_lock(lock[1]), .r1_gnt(o_gnt[1][1]),
        .r1_rvalid(o_rv[1][1]), .r1_rdata(o_rd[1][1]),
        .mem_addr(o_addr[1]), .mem_size(o_size[1]), .mem_wdata(o_wd[1]), .mem_we(o_we[1]),
        .mem_rdata(m_rdata[1])
    );

    function automatic logic [31:0] rd(input logic [31:0] a, input logic [1:0] s);
        logic [7:0] b;
        b = a[7:0];
        case (s)
            2'b00:   rd = {24'd0, mem[b]};
            2'b01:   rd = {16'd0, mem[b + 8'd1], mem[b]};
            default: rd = {mem[b + 8'd3], mem[b + 8'd2], mem[b + 8'd1], mem[b]};
        endcase
    endfunction

    always_comb begin
        m_rdata[0] = rd(o_addr[0], o_size[0]);
        m_rdata[1] = rd(o_addr[1], o_size[1]);
    end

    // Mem model: only the round-robin instance writes; byte lanes follow mem_size.
    always @(posedge CLK) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
            mem[8'h40] <= 8'hDE;
            mem[8'h41] <= 8'hAD;
            mem[8'h42] <= 8'hBE;
            mem[8'h43] <= 8'hEF;
            mem_init   <= 1'b1;
        end else if (o_we[0]) begin
            mem[o_addr[0][7:0]] <= o_wd[0][7:0];
            if (o_size[0] != 2'b00) mem[o_addr[0][7:0] + 8'd1] <= o_wd[0][15:8];
            if (o_size[0][1]) begin
                mem[o_addr[0][7:0] + 8'd2] <= o_wd[0][23:16];
                mem[o_addr[0][7:0] + 8'd3] <= o_wd[0][31:24];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Winner under the arbitration rules for instance m; -1 means nobody.
    function automatic int pick(input int m);
        int o;
        if (!RST) return -1;
        o = own_m[m];
        if (o >= 0 && req[o]) begin
            if (held_m[m] == MAXL && req[1 - o]) return 1 - o;
            return o;
        end
        if (req[0] && req[1]) return (m == 0) ? 1 - last_m[m] : 0;
        if (req[0]) return 0;
        if (req[1]) return 1;
        return -1;
    endfunction

    always @(negedge CLK) begin
        for (int m = 0; m < 2; m++) begin
            if (!RST) begin
                chk($sformatf("m%0d rst gnt", m), 32'(o_gnt[m]), 32'd0);
                chk($sformatf("m%0d rst mem_we", m), 32'(o_we[m]), 32'd0);
                chk($sformatf("m%0d rst rvalid", m), 32'(o_rv[m]), 32'd0);
                chk($sformatf("m%0d rst rdata0", m), o_rd[m][0], 32'd0);
                chk($sformatf("m%0d rst rdata1", m), o_rd[m][1], 32'd0);
                own_m[m]  = -1;
                held_m[m] = 0;
                last_m[m] = 1;
                for (int k = 0; k < 2; k++) begin
                    erv[m][k] = 1'b0;
                    erd[m][k] = 32'd0;
                end
            end else begin
                int w;
                logic [1:0] eg;
                for (int k = 0; k < 2; k++) begin
                    chk($sformatf("m%0d r%0d rvalid", m, k), 32'(o_rv[m][k]), 32'(erv[m][k]));
                    chk($sformatf("m%0d r%0d rdata", m, k), o_rd[m][k], erd[m][k]);
                end
                w  = pick(m);
                eg = (w == 0) ? 2'b01 : (w == 1) ? 2'b10 : 2'b00;
                chk($sformatf("m%0d gnt", m), 32'(o_gnt[m]), 32'(eg));
                chk($sformatf("m%0d mem_we", m), 32'(o_we[m]), (w >= 0) ? 32'(we[w]) : 32'd0);
                if (w >= 0) begin
                    chk($sformatf("m%0d mem_addr", m), o_addr[m], addr_i[w]);
                    chk($sformatf("m%0d mem_size", m), 32'(o_size[m]), 32'(size_i[w]));
                    chk($sformatf("m%0d mem_wdata", m), o_wd[m], wdata_i[w]);
                end
                for (int k = 0; k < 2; k++) begin
                    erv[m][k] = (w == k) && !we[k];
                    if (erv[m][k]) erd[m][k] = rd(addr_i[k], size_i[k]);
                end
                if (w >= 0) begin
                    if (lock[w]) begin
                        held_m[m] = (own_m[m] == w) ? ((held_m[m] < MAXL) ? held_m[m] + 1 : MAXL) : 1;
                        own_m[m]  = w;
                    end else begin
                        own_m[m]  = -1;
                        held_m[m] = 0;
                    end
                    last_m[m] = w;
                end else begin
                    own_m[m]  = -1;
                    held_m[m] = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] seq_f, seq_p, seq1_p, seq1_f;
        RST        = 1'b0;
        req        = 2'b11;
        we         = 2'b11;
        lock       = 2'b00;
        addr_i[0]  = 32'h40;
        addr_i[1]  = 32'h44;
        size_i[0]  = 2'b10;
        size_i[1]  = 2'b10;
        wdata_i[0] = 32'h0;
        wdata_i[1] = 32'h0;

        // Reset with both requesting, then release: r0 first, single word load.
        repeat (2) step();
        @(negedge CLK);
        chk("lit rst gnt", 32'(o_gnt[0]), 32'd0);
        chk("lit rst mem_we", 32'(o_we[0]), 32'd0);
        step();
        RST = 1'b1;
        we  = 2'b00;
        @(negedge CLK);
        chk("lit first gnt rr", 32'(o_gnt[0]), 32'h1);
        chk("lit first gnt fp", 32'(o_gnt[1]), 32'h1);
        step();
        req = 2'b00;
        @(negedge CLK);
        chk("lit load rvalid", 32'(o_rv[0][0]), 32'd1);
        chk("lit load rdata", o_rd[0][0], 32'hEFBEADDE);

        // Continuous contention without lock.
        step();
        req = 2'b11;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            seq_f[i]  = o_gnt[0][0];
            seq_p[i]  = o_gnt[1][0];
            seq1_p[i] = o_gnt[1][1];
            step();
        end
        chk("lit rr alternation", 32'(seq_f), 32'hAA);
        chk("lit fp r0 always", 32'(seq_p), 32'hFF);
        chk("lit fp r1 never", 32'(seq1_p), 32'h00);

        // r1 alone once so r0 is favoured, then r0 locks against a waiting r1.
        req = 2'b10;
        step();
        lock[0] = 1'b1;
        req     = 2'b11;
        seq_f   = 8'd0;
        seq_p   = 8'd0;
        seq1_f  = 8'd0;
        for (int i = 0; i < 7; i++) begin
            @(negedge CLK);
            seq_f[i]  = o_gnt[0][0];
            seq1_f[i] = o_gnt[0][1];
            seq_p[i]  = o_gnt[1][0];
            step();
        end
        chk("lit lock r0 rr", 32'(seq_f), 32'h6F);
        chk("lit lock r1 rr", 32'(seq1_f), 32'h10);
        chk("lit lock r0 fp", 32'(seq_p), 32'h6F);

        // Owner alone past saturation, then drop.
        req = 2'b01;
        repeat (6) step();
        req  = 2'b00;
        lock = 2'b00;
        step();

        // Store/load collision on 0x80: r1 store wins, r0 load follows.
        we         = 2'b10;
        addr_i[0]  = 32'h80;
        addr_i[1]  = 32'h80;
        wdata_i[1] = 32'h11223344;
        req        = 2'b11;
        @(negedge CLK);
        chk("lit coll gnt", 32'(o_gnt[0]), 32'h2);
        chk("lit coll mem_we", 32'(o_we[0]), 32'd1);
        step();
        req = 2'b01;
        @(negedge CLK);
        chk("lit coll r0 gnt", 32'(o_gnt[0]), 32'h1);
        step();
        req = 2'b00;
        @(negedge CLK);
        chk("lit coll rvalid", 32'(o_rv[0][0]), 32'd1);
        chk("lit coll rdata", o_rd[0][0], 32'h11223344);

        // Byte store at 0x85.
        step();
        we         = 2'b01;
        addr_i[0]  = 32'h85;
        size_i[0]  = 2'b00;
        wdata_i[0] = 32'h000000AB;
        req        = 2'b01;
        @(negedge CLK);
        chk("lit byte mem_size", 32'(o_size[0]), 32'd0);
        chk("lit byte mem_we", 32'(o_we[0]), 32'd1);
        step();
        req = 2'b00;
        @(negedge CLK);
        chk("lit byte 85", 32'(mem[8'h85]), 32'hAB);
        chk("lit byte 84", 32'(mem[8'h84]), 32'h84);
        chk("lit byte 86", 32'(mem[8'h86]), 32'h86);

        // Reset in the middle of a locked store sequence suppresses the pending write.
        step();
        addr_i[0]  = 32'h90;
        size_i[0]  = 2'b10;
        wdata_i[0] = 32'hCAFEF00D;
        lock[0]    = 1'b1;
        req        = 2'b01;
        step();
        addr_i[0]  = 32'h94;
        wdata_i[0] = 32'h12345678;
        RST        = 1'b0;
        @(negedge CLK);
        chk("lit midrst mem_we", 32'(o_we[0]), 32'd0);
        chk("lit midrst gnt", 32'(o_gnt[0]), 32'd0);
        step();
        RST  = 1'b1;
        req  = 2'b00;
        lock = 2'b00;
        @(negedge CLK);
        chk("lit midrst 94", 32'(mem[8'h94]), 32'h94);
        chk("lit midrst 90", 32'(mem[8'h90]), 32'h0D);
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
